// File: rtl/bootrom_arbiter.sv
// bootrom_arbiter: shares one synchronous boot ROM port between two read requesters.
// Round-robin with a bounded burst allowance; read data returns one cycle after grant.
module bootrom_arbiter #(
    parameter int AW        = 8,
    parameter int DW        = 32,
    parameter int BURST_MAX = 4
) (
    input  logic          CLK,
    input  logic          RESETn,
    input  logic          R0_REQ,
    input  logic          R1_REQ,
    input  logic [AW-1:0] R0_ADDR,
    input  logic [AW-1:0] R1_ADDR,
    output logic          R0_GNT,
    output logic          R1_GNT,
    output logic          R0_RVALID,
    output logic          R1_RVALID,
    output logic [DW-1:0] R0_RDATA,
    output logic [DW-1:0] R1_RDATA,
    output logic          ROM_EN,
    output logic [AW-1:0] ROM_ADDR,
    input  logic [DW-1:0] ROM_RDATA
);
    logic       r_owner;
    logic [3:0] r_count;
    logic       r_rsp_valid;
    logic       r_rsp_id;
    logic       w_keep;
    logic       w_pick0;

    // Under contention port 0 wins when it owns and has allowance left, or when port 1 has used its run up.
    assign w_keep  = r_count < 4'(BURST_MAX);
    assign w_pick0 = ~R1_REQ | (r_owner == ~w_keep);
    assign R0_GNT  = RESETn & R0_REQ & w_pick0;
    assign R1_GNT  = RESETn & R1_REQ & ~R0_GNT;
    assign ROM_EN  = R0_GNT | R1_GNT;
    assign ROM_ADDR = R1_GNT ? R1_ADDR : (R0_GNT ? R0_ADDR : '0);

    assign R0_RVALID = r_rsp_valid & ~r_rsp_id;
    assign R1_RVALID = r_rsp_valid & r_rsp_id;
    assign R0_RDATA  = ROM_RDATA;
    assign R1_RDATA  = ROM_RDATA;

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            r_owner     <= 1'b0;
            r_count     <= 4'd0;
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= 1'b0;
        end else begin
            r_rsp_valid <= ROM_EN;
            r_rsp_id    <= R1_GNT;
            if (!ROM_EN)
                r_count <= 4'd0;
            else if (R1_GNT == r_owner)
                r_count <= (r_count == 4'hF) ? r_count : r_count + 4'd1;
            else begin
                r_owner <= R1_GNT;
                r_count <= 4'd1;
            end
        end
    end
endmodule

// File: tb/tb_bootrom_arbiter.sv
// tb_bootrom_arbiter: table vectors, hand sequences and randomized traffic checked
// against a grant-history reference model and a stub ROM.
module tb_bootrom_arbiter;
    localparam int AW = 8;
    localparam int DW = 32;
    localparam int BM = 4;

    logic          CLK = 1'b0;
    logic          RESETn = 1'b0;
    logic          R0_REQ = 1'b0, R1_REQ = 1'b0;
    logic [AW-1:0] R0_ADDR = '0, R1_ADDR = '0;
    logic          R0_GNT, R1_GNT, R0_RVALID, R1_RVALID, ROM_EN;
    logic [DW-1:0] R0_RDATA, R1_RDATA, rom_q;
    logic [AW-1:0] ROM_ADDR;

    bootrom_arbiter #(.AW(AW), .DW(DW), .BURST_MAX(BM)) dut (
        .CLK(CLK), .RESETn(RESETn),
        .R0_REQ(R0_REQ), .R1_REQ(R1_REQ), .R0_ADDR(R0_ADDR), .R1_ADDR(R1_ADDR),
        .R0_GNT(R0_GNT), .R1_GNT(R1_GNT), .R0_RVALID(R0_RVALID), .R1_RVALID(R1_RVALID),
        .R0_RDATA(R0_RDATA), .R1_RDATA(R1_RDATA),
        .ROM_EN(ROM_EN), .ROM_ADDR(ROM_ADDR), .ROM_RDATA(rom_q)
    );

    always #5 CLK = ~CLK;

    function automatic logic [DW-1:0] rom_word(input logic [AW-1:0] a);
        return {a, ~a, a ^ 8'hA5, a + 8'd1};
    endfunction

    always @(posedge CLK) if (ROM_EN) rom_q <= rom_word(ROM_ADDR);

    int n_cmp = 0, n_err = 0;
    int hist[$];
    bit pend_v = 0;
    int pend_id = 0;
    logic [AW-1:0] pend_a = '0;
    int s_g = -1;
    bit chk_proto = 0;

    typedef struct {
        logic r0, r1;
        logic [AW-1:0] a0, a1;
        int eg;
    } vec_t;
    vec_t tbl[$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference: owner is the last port granted; its run is the number of trailing
    // consecutive grants to it with no idle cycle in between.
    function automatic int exp_grant(input logic r0, input logic r1);
        int own, run;
        if (!RESETn || (!r0 && !r1)) return -1;
        if (r0 && !r1) return 0;
        if (r1 && !r0) return 1;
        own = 0;
        for (int i = hist.size() - 1; i >= 0; i--)
            if (hist[i] >= 0) begin own = hist[i]; break; end
        run = 0;
        for (int i = hist.size() - 1; i >= 0; i--) begin
            if (hist[i] != own) break;
            run++;
        end
        return (run < BM) ? own : 1 - own;
    endfunction

    task automatic step(input logic r0, input logic r1, input logic [AW-1:0] a0, input logic [AW-1:0] a1);
        int eg;
        logic [AW-1:0] ea;
        R0_REQ = r0; R1_REQ = r1; R0_ADDR = a0; R1_ADDR = a1;
        #4;
        eg = exp_grant(r0, r1);
        ea = (eg == 0) ? a0 : (eg == 1) ? a1 : '0;
        chk("gnt0", R0_GNT, eg == 0);
        chk("gnt1", R1_GNT, eg == 1);
        chk("rom_en", ROM_EN, eg >= 0);
        chk("rom_addr", ROM_ADDR, ea);
        chk("rvalid0", R0_RVALID, pend_v && pend_id == 0);
        chk("rvalid1", R1_RVALID, pend_v && pend_id == 1);
        if (pend_v) chk(pend_id ? "rdata1" : "rdata0", pend_id ? R1_RDATA : R0_RDATA, rom_word(pend_a));
        s_g = R1_GNT ? 1 : (R0_GNT ? 0 : -1);
        if (R0_GNT && R1_GNT) s_g = 2;
        if (RESETn) hist.push_back(eg);
        pend_v = eg >= 0; pend_id = eg; pend_a = ea;
        @(posedge CLK); #1;
    endtask

    task automatic do_reset();
        RESETn = 1'b0; R0_REQ = 0; R1_REQ = 0;
        hist.delete(); pend_v = 0;
        repeat (2) @(posedge CLK);
        #1 RESETn = 1'b1;
    endtask

    always @(negedge CLK) assert (!(R0_GNT && R1_GNT)) else $error("two grants in one cycle");

    logic p_r0 = 0, p_r1 = 0, p_g0 = 0, p_g1 = 0;
    logic [AW-1:0] p_a0 = '0, p_a1 = '0;
    always @(posedge CLK) begin
        if (chk_proto && RESETn) begin
            if (p_r0 && !p_g0) assert (R0_REQ && R0_ADDR == p_a0) else $error("port0 dropped request");
            if (p_r1 && !p_g1) assert (R1_REQ && R1_ADDR == p_a1) else $error("port1 dropped request");
        end
        p_r0 <= R0_REQ && RESETn; p_r1 <= R1_REQ && RESETn;
        p_g0 <= R0_GNT; p_g1 <= R1_GNT; p_a0 <= R0_ADDR; p_a1 <= R1_ADDR;
    end

    initial begin
        logic q0, q1, g0l, g1l;
        logic [AW-1:0] ra0, ra1;
        int seq_a[] = '{0,0,0,0,1,1,1,1,0,0,-1,0,0,0,0,1,-1,1,1,1,1,0};
        int seq_r[] = '{3,3,3,3,3,3,3,3,3,3, 0,3,3,3,3,3, 0,2,2,3,3,3};

        RESETn = 1'b0;
        #2;
        chk("rst_gnt0", R0_GNT, 0);
        chk("rst_rom_en", ROM_EN, 0);
        chk("rst_rvalid0", R0_RVALID, 0);
        chk("rst_rvalid1", R1_RVALID, 0);
        do_reset();

        // Port 0 streaming 0x00..0x07
        for (int i = 0; i < 8; i++) begin
            step(1, 0, AW'(i), 8'h33);
            chk("p0_stream_gnt", s_g, 0);
        end
        step(0, 0, 0, 0);

        // Contention, idle restart, and port 1 joined by port 0
        do_reset();
        for (int i = 0; i < seq_a.size(); i++)
            tbl.push_back('{seq_r[i][0], seq_r[i][1], AW'(i), AW'(8'h80 + i), seq_a[i]});
        foreach (tbl[i]) begin
            step(tbl[i].r0, tbl[i].r1, tbl[i].a0, tbl[i].a1);
            chk("tbl_gnt", s_g, tbl[i].eg);
        end
        step(0, 0, 0, 0);

        // Reset pulsed while a response to 0xFF is outstanding
        step(1, 0, 8'hFF, 0);
        RESETn = 1'b0;
        hist.delete(); pend_v = 0;
        #1;
        chk("rst_mid_rvalid0", R0_RVALID, 0);
        step(1, 1, 8'h10, 8'h20);
        step(1, 1, 8'h10, 8'h20);
        RESETn = 1'b1;
        step(0, 0, 0, 0);
        chk("post_rst_rvalid", R0_RVALID | R1_RVALID, 0);
        step(1, 1, 8'h11, 8'h21);
        chk("post_rst_owner", s_g, 0);

        // Port 1 address boundaries
        do_reset();
        step(0, 1, 0, 8'h00);
        step(0, 1, 0, 8'hFF);
        step(0, 0, 8'h5A, 8'hA5);
        chk("idle_rom_addr", ROM_ADDR, 0);
        step(0, 0, 0, 0);

        // Randomized traffic obeying the hold-until-granted rule
        chk_proto = 1;
        q0 = 0; q1 = 0; g0l = 0; g1l = 0; ra0 = 0; ra1 = 0;
        for (int i = 0; i < 600; i++) begin
            if (!(q0 && !g0l)) begin q0 = $urandom_range(0, 9) < 7; ra0 = AW'($urandom); end
            if (!(q1 && !g1l)) begin q1 = $urandom_range(0, 9) < 6; ra1 = AW'($urandom); end
            step(q0, q1, ra0, ra1);
            g0l = (s_g == 0); g1l = (s_g == 1);
        end
        step(0, 0, 0, 0);
        chk_proto = 0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/bootrom_arbiter.md
# bootrom_arbiter

Two-requester arbiter that shares the single-port synchronous boot ROM between a primary requester (port 0, CPU instruction fetch) and a secondary requester (port 1, debug/loader read path). It accepts one word read per cycle from the winning requester, drives the ROM enable and word address, and returns the ROM read data one cycle later to the requester that issued the access. Fairness uses round-robin with a bounded burst allowance, so a streaming fetcher cannot starve the other port. It sits between the two bus-side read paths and the `bootrom` wrapper.

## Interface
- `AW`, 8, ROM word-address width; must match the ROM wrapper address width
- `DW`, 32, data width
- `BURST_MAX`, 4, consecutive grants the current owner may take while the other port is also requesting; legal range 1..15
- `CLK`  in  1  clock; all state on rising edge
- `RESETn`  in  1  asynchronous, active-low reset
- `R0_REQ`, `R1_REQ`  in  1  read request; held with address until granted
- `R0_ADDR`, `R1_ADDR`  in  AW  word address
- `R0_GNT`, `R1_GNT`  out  1  request accepted this cycle (combinational)
- `R0_RVALID`, `R1_RVALID`  out  1  read data valid this cycle (registered)
- `R0_RDATA`, `R1_RDATA`  out  DW  read data; both ports carry `ROM_RDATA` unconditionally
- `ROM_EN`  out  1  ROM access enable (active high; the wrapper inverts it to CEN)
- `ROM_ADDR`  out  AW  ROM word address
- `ROM_RDATA`  in  DW  ROM output, valid the cycle after an `ROM_EN` cycle

## Operation
- State: `owner` (1 bit), `count` (4 bits), `rsp_valid` (1 bit), `rsp_id` (1 bit).
- Grant decision in every cycle, combinational on `R*_REQ`, `owner` and `count`:
  - No request: no grant, `ROM_EN`=0, `count`←0, `owner` unchanged.
  - One request: grant that port. If port == `owner`, `count`←min(`count`+1, 15). Otherwise `owner`←port and `count`←1.
  - Both requesting and `count` < `BURST_MAX`: grant `owner`, `count`←`count`+1.
  - Both requesting and `count` ≥ `BURST_MAX`: grant the other port, `owner`←other, `count`←1.
- At most one `GNT` is high in any cycle. `ROM_EN` = OR of the `GNT` signals. `ROM_ADDR` = the granted port's address, or 0 when idle.
- Response: `rsp_valid`←`ROM_EN` and `rsp_id`←granted port, every cycle. `Rn_RVALID` = `rsp_valid` & (`rsp_id`==n).
- A port with a response pending can be granted again in the same cycle, giving full pipelining at one read per cycle.
- Requesters must not drop `REQ` or change `ADDR` before `GNT`. Such behaviour is a protocol violation; the bench flags it as an assertion, and the RTL does not check it.
- Reset values: `owner`=0, `count`=0, `rsp_valid`=0, `rsp_id`=0. All `GNT` and `RVALID` outputs are 0 and `ROM_EN`=0 while `RESETn` is low.
- Reset asserted mid-access: the outstanding response is discarded. No `RVALID` appears after reset is released unless a new grant occurs.

## Timing
- Grant latency: 0 cycles. `GNT` is in the same cycle as `REQ` when the port wins.
- Read latency: `RVALID` and `RDATA` appear exactly 1 cycle after the `GNT` cycle.
- Throughput: 1 read per cycle aggregate.
- Worst-case wait for a continuously requesting port: `BURST_MAX` cycles.
- Back-to-back alternation under contention with `BURST_MAX`=1: grants go 0,1,0,1,...
- Output paths: `GNT`, `ROM_EN` and `ROM_ADDR` are combinational from the request inputs. `RVALID` is a flop output, and `RDATA` is a direct wire from the ROM.

## Test plan
- Reset, then port 0 only, reads addresses 0x00..0x07 back-to-back → `R0_GNT`=1 on every cycle, `R0_RVALID` on the next 8 cycles, data matches the ROM image, `R1_RVALID` stays 0.
- Both ports request continuously, `BURST_MAX`=4, from reset → grant sequence 0,0,0,0,1,1,1,1,0,... and each `RVALID` lands on the correct port one cycle after its grant.
- Port 1 requests alone for 2 cycles, then port 0 joins → port 1 keeps the grant until `count`=4, then port 0 is granted. Exactly one `GNT` per cycle, checked by assertion.
- One idle cycle inserted mid-contention (both `REQ` low) → `count` resets. The next contended cycle grants the current `owner` for a fresh `BURST_MAX` run.
- Port 0 granted at address 0xFF, `RESETn` pulsed low on the following cycle → no `RVALID` during or after reset, and the first post-reset grant goes to port 0 (`owner`=0).
- Address boundaries: reads at 0x00 and 0xFF from port 1 → correct ROM words returned, and `ROM_ADDR` returns to 0 when idle.
